// File: rtl/pkg_mpu.sv
// MPU-side shared types.
// Issue numbers travel from the MPU issue stage through every commit path.
// Width is fixed here so all consumers agree on one encoding.
package pkg_mpu;

  typedef logic [7:0] mpu_issue_no_t;

endpackage

// File: rtl/pkg_top.sv
// Top-level system sizing shared by the MPU/TPU cluster.
// NUM_TPU sets the commit fan-in; BYPASS_BUFF_SIZE sets the commit tracker depth.
// tpu_mask_t is the per-issue TPU participation mask.
package pkg_top;

  localparam int NUM_TPU          = 16;
  localparam int BYPASS_BUFF_SIZE = 8;

  typedef logic [NUM_TPU-1:0] tpu_mask_t;

endpackage

// File: rtl/commit_match.sv
// Finds, for one TPU commit, the oldest tracked entry (searched from head) that it clears.
// Latency: purely combinational.
// Backpressure: none; a miss is reported through hit_o low and is the caller's to flag.
module commit_match
  import pkg_mpu::*;
#(
  parameter int BUFF_SIZE = 8,
  parameter int NO_WIDTH  = $bits(mpu_issue_no_t)
) (
  input  logic                                 req_i,
  input  logic [NO_WIDTH-1:0]                  commit_no_i,
  input  logic [$clog2(BUFF_SIZE)-1:0]         head_i,
  input  logic [BUFF_SIZE-1:0]                 cand_i,
  input  logic [BUFF_SIZE-1:0][NO_WIDTH-1:0]   no_i,
  output logic [BUFF_SIZE-1:0]                 sel_o,
  output logic                                 hit_o
);

  localparam int PTR_W = $clog2(BUFF_SIZE);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Walk entries in age order starting at head; first candidate with matching number wins.
  always_comb begin
    sel_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < BUFF_SIZE; k++) begin
      idx = head_i + PTR_W'(k);
      if (!found && cand_i[idx] && (no_i[idx] == commit_no_i)) begin
        sel_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    hit_o = req_i && found;
    if (!req_i) begin
      sel_o = '0;
    end
  end

endmodule

// File: rtl/commit_agg_ooo.sv
// Collects out-of-order per-TPU commits and retires issues to the MPU strictly in issue order.
// Latency: last clearing commit at edge k -> O_Commit_Req in the cycle after edge k+1.
// Backpressure: none; issues while full and unmatched commits are dropped and flagged on O_Err.
module commit_agg_ooo
  import pkg_mpu::*;
#(
  parameter int NUM_TPU   = pkg_top::NUM_TPU,
  parameter int BUFF_SIZE = pkg_top::BYPASS_BUFF_SIZE,
  parameter int NO_WIDTH  = $bits(mpu_issue_no_t)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             I_Req,
  input  logic [NO_WIDTH-1:0]              I_Issue_No,
  input  logic [NUM_TPU-1:0]               I_En_TPU,
  input  logic [NUM_TPU-1:0]               I_Commit_Req,
  input  logic [NUM_TPU-1:0][NO_WIDTH-1:0] I_Commit_No,
  output logic                             O_Commit_Req,
  output logic [NO_WIDTH-1:0]              O_Commit_No,
  output logic                             O_Full,
  output logic                             O_Empty,
  output logic [$clog2(BUFF_SIZE):0]       O_Count,
  output logic                             O_Err
);

  localparam int PTR_W = $clog2(BUFF_SIZE);
  localparam int CNT_W = PTR_W + 1;

  // Tracking buffer: one slot per in-flight issue, ring-addressed by head/tail.
  logic [BUFF_SIZE-1:0]                valid_q, valid_d;
  logic [BUFF_SIZE-1:0][NO_WIDTH-1:0]  no_q, no_d;
  logic [BUFF_SIZE-1:0][NUM_TPU-1:0]   pend_q, pend_d;
  logic [PTR_W-1:0]                    head_q, head_d;
  logic [PTR_W-1:0]                    tail_q, tail_d;
  logic [CNT_W-1:0]                    count_q, count_d;
  logic                                full_q, empty_q;
  logic                                commit_req_q, commit_req_d;
  logic [NO_WIDTH-1:0]                 commit_no_q, commit_no_d;
  logic                                err_q, err_d;

  logic [NUM_TPU-1:0][BUFF_SIZE-1:0]   cand;
  logic [NUM_TPU-1:0][BUFF_SIZE-1:0]   sel;
  logic [NUM_TPU-1:0]                  hit;
  logic                                issue_ok;
  logic                                retire;

  // Per-TPU view of which slots still wait on that TPU.
  always_comb begin
    cand = '0;
    for (int t = 0; t < NUM_TPU; t++) begin
      for (int e = 0; e < BUFF_SIZE; e++) begin
        cand[t][e] = valid_q[e] & pend_q[e][t];
      end
    end
  end

  for (genvar t = 0; t < NUM_TPU; t++) begin : g_match
    commit_match #(
      .BUFF_SIZE (BUFF_SIZE),
      .NO_WIDTH  (NO_WIDTH)
    ) u_match (
      .req_i       (I_Commit_Req[t]),
      .commit_no_i (I_Commit_No[t]),
      .head_i      (head_q),
      .cand_i      (cand[t]),
      .no_i        (no_q),
      .sel_o       (sel[t]),
      .hit_o       (hit[t])
    );
  end

  // Next state: apply all commit clears, retire a completed head, accept an issue at tail.
  // A retiring head has an empty mask so no commit can target it, and the tail slot is
  // never valid when an issue is accepted, so the three updates never touch the same bits.
  always_comb begin
    valid_d      = valid_q;
    no_d         = no_q;
    pend_d       = pend_q;
    head_d       = head_q;
    tail_d       = tail_q;
    commit_req_d = 1'b0;
    commit_no_d  = commit_no_q;
    issue_ok     = I_Req && !full_q;
    retire       = valid_q[head_q] && (pend_q[head_q] == '0);

    for (int e = 0; e < BUFF_SIZE; e++) begin
      for (int t = 0; t < NUM_TPU; t++) begin
        if (hit[t] && sel[t][e]) begin
          pend_d[e][t] = 1'b0;
        end
      end
    end

    if (retire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
      commit_req_d    = 1'b1;
      commit_no_d     = no_q[head_q];
    end

    if (issue_ok) begin
      valid_d[tail_q] = 1'b1;
      no_d[tail_q]    = I_Issue_No;
      pend_d[tail_q]  = I_En_TPU;
      tail_d          = tail_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(issue_ok) - CNT_W'(retire);
    err_d   = (I_Req && full_q) || (|(I_Commit_Req & ~hit));
  end

  // State and registered status/outputs; reset discards everything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= '0;
      no_q         <= '0;
      pend_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      commit_req_q <= 1'b0;
      commit_no_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      no_q         <= no_d;
      pend_q       <= pend_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      full_q       <= (count_d == CNT_W'(BUFF_SIZE));
      empty_q      <= (count_d == '0);
      commit_req_q <= commit_req_d;
      commit_no_q  <= commit_no_d;
      err_q        <= err_d;
    end
  end

  assign O_Commit_Req = commit_req_q;
  assign O_Commit_No  = commit_no_q;
  assign O_Full       = full_q;
  assign O_Empty      = empty_q;
  assign O_Count      = count_q;
  assign O_Err        = err_q;

endmodule

// File: doc/commit_agg_ooo.md
COMMIT_AGG_OOO -- requirements
Module: commit_agg_ooo

Interface
REQ-001 Parameter NUM_TPU, default 16: number of TPU commit channels (1..64).
REQ-002 Parameter BUFF_SIZE, default 8: tracking-buffer depth, power of two, 2..32.
REQ-003 Parameter NO_WIDTH, default $bits(mpu_issue_no_t): issue-number width.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 I_Req  in  1  issue strobe from MPU, one entry per asserted cycle.
REQ-007 I_Issue_No  in  NO_WIDTH  issue number of the issued instruction.
REQ-008 I_En_TPU  in  NUM_TPU  mask of TPUs that must commit this issue.
REQ-009 I_Commit_Req  in  NUM_TPU  per-TPU commit strobe.
REQ-010 I_Commit_No  in  NUM_TPU x NO_WIDTH  per-TPU committed issue number.
REQ-011 O_Commit_Req  out  1  aggregated in-order commit pulse to MPU.
REQ-012 O_Commit_No  out  NO_WIDTH  issue number retired with O_Commit_Req.
REQ-013 O_Full  out  1  buffer holds BUFF_SIZE entries.
REQ-014 O_Empty  out  1  buffer holds zero entries.
REQ-015 O_Count  out  $clog2(BUFF_SIZE)+1  current entry count.
REQ-016 O_Err  out  1  one-cycle pulse on overflow or unmatched commit.

Function
REQ-017 Each entry SHALL hold valid bit, issue number, NUM_TPU-bit pending mask; head/tail pointers wrap modulo BUFF_SIZE.
REQ-018 I_Req with O_Full low SHALL write entry at tail with pending = I_En_TPU and advance tail at the same edge.
REQ-019 I_Req with O_Full high SHALL be dropped and SHALL pulse O_Err next cycle; a same-cycle retire does not make room.
REQ-020 Each TPU i with I_Commit_Req[i] high SHALL clear bit i in the oldest valid entry (searched from head) whose number equals I_Commit_No[i] and whose bit i is set.
REQ-021 Any number of TPUs SHALL commit in one cycle, to same or different entries; all matches apply at one edge.
REQ-022 Commits match only entries valid before the edge; a commit for an entry issued in the same cycle is unmatched.
REQ-023 Unmatched commit (no entry, or bit already clear) SHALL change no state and SHALL pulse O_Err next cycle.
REQ-024 When head entry is valid with pending mask zero, the block SHALL retire it: O_Commit_Req high for exactly one cycle after the next edge, O_Commit_No = its number, head advances, valid cleared.
REQ-025 At most one retire per cycle; completed younger entries wait for all older entries (strict issue order).
REQ-026 Latency: last clearing commit sampled at edge k -> O_Commit_Req high in cycle after edge k+1; zero-mask issue at edge k -> retire in cycle after edge k+1.
REQ-027 Simultaneous issue and retire SHALL leave O_Count unchanged; O_Full/O_Empty/O_Count are registered and reflect state after each edge.
REQ-028 O_Commit_No SHALL hold its last value while O_Commit_Req is low.

Reset
REQ-029 Reset SHALL clear all valid bits and pending masks, head = tail = 0, O_Count = 0, O_Empty = 1, O_Full = 0, O_Commit_Req = 0, O_Commit_No = 0, O_Err = 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight entries without emitting any commit; inputs during reset are ignored.

Structure
REQ-031 mpu_issue_no_t stays in pkg_mpu; NUM_TPU, BYPASS_BUFF_SIZE and a tpu_mask_t (NUM_TPU bits) belong in pkg_top.
REQ-032 One sub-module, commit_match: combinational per-TPU oldest-match search from head, returning one-hot entry select and a hit flag; instantiated NUM_TPU times.

Verification
REQ-033 Issue no 5 mask 0x3; TPU1 commits 5, then TPU0 commits 5 two cycles later -> single O_Commit_Req, O_Commit_No=5, 2 cycles after TPU0 commit.
REQ-034 Issue 1,2 (mask 0x1 each); TPU0 commits 2 then 1 -> retire 1 then 2 on consecutive cycles.
REQ-035 Fill BUFF_SIZE=8 entries, issue 9th -> O_Full=1, O_Err pulse, O_Count=8, 9th never retired.
REQ-036 TPU3 commits 7 with no entry 7 -> O_Err pulse, O_Count unchanged, no O_Commit_Req.
REQ-037 Issue no 4 with mask 0 -> O_Commit_Req with O_Commit_No=4 one cycle after issue edge; issue 4 twice, commit once -> only oldest retires.
REQ-038 Reset asserted with 3 pending entries -> O_Count=0, O_Empty=1 next cycle, no O_Commit_Req; pointer wrap exercised over 3xBUFF_SIZE issues.
